datapath_controller: RTL and testbench
======================================

// Module: datapath_controller
// PURPOSE
//  Moore FSM that sequences the regfile/ALU datapath for one 16-bit instruction at a time.
//  Takes the decoded opcode/op from the instruction register and a start strobe.
//  Drives register select, pipeline register loads, writeback mux and regfile write enable.
//  Raises w when idle and ready to accept the next instruction.
// PARAMETERS
//  OPC_MOV  3'b110  opcode of MOV class (op 2'b10 = MOV Rn,#imm8; op 2'b00 = MOV Rd,Rm)
//  OPC_ALU  3'b101  opcode of ALU class (op 00 ADD, 01 CMP, 10 AND, 11 MVN)
// PORTS
//  clk      in   1  rising-edge clock
//  reset    in   1  asynchronous, active-high; forces WAIT
//  s        in   1  start; sampled only in WAIT
//  opcode   in   3  instruction bits [15:13]
//  op       in   2  instruction bits [12:11]
//  nsel     out  3  one-hot register select: 001 Rm, 010 Rd, 100 Rn, 000 none
//  vsel     out  2  writeback source: 00 ALU result C, 01 sign-extended imm8 (10/11 never driven)
//  loada    out  1  load A pipeline register
//  loadb    out  1  load B pipeline register
//  asel     out  1  1 = ALU A operand forced to 0
//  bsel     out  1  1 = ALU B operand from imm5 (never driven 1 by this block)
//  loadc    out  1  load C result register
//  loads    out  1  load status flags
//  write    out  1  regfile write enable
//  w        out  1  1 = idle in WAIT, ready for s
// BEHAVIOUR
//  - States: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, EXEC, WRITE_REG; 3-bit encoded state register.
//  - Reset (async): state=WAIT; w=1, all other outputs 0, including nsel=000 and vsel=00.
//  - Reset mid-instruction: aborts immediately, no write is issued afterwards.
//  - Outputs are a pure function of state plus the latched opcode/op.
//  - Default value of every output not listed for a state is 0.
//  - Latching: opcode/op are captured on the edge leaving WAIT (s=1).
//  - Input changes after that edge are ignored until the next WAIT.
//  - WAIT: w=1. s=1 -> DECODE, else stay.
//  - DECODE: from the latched opcode/op:
//    MOV imm -> WRITE_IMM
//    MOV reg or MVN -> GET_B
//    ADD/CMP/AND -> GET_A
//    any other opcode/op -> WAIT (illegal: no loads, no write)
//  - WRITE_IMM: nsel=100, vsel=01, write=1 -> WAIT.
//  - GET_A: nsel=100, loada=1 -> GET_B.
//  - GET_B: nsel=001, loadb=1 -> EXEC.
//  - EXEC: loadc=1, and:
//    asel=1 for MOV reg and MVN
//    loads=1 for CMP only
//    next: CMP -> WAIT; all others -> WRITE_REG
//    CMP asserts loadc=0, so C is untouched.
//  - WRITE_REG: nsel=010, vsel=00, write=1 -> WAIT.
//  - Latency, counted from the edge sampling s=1 to the edge at which w returns high:
//    MOV imm 2, CMP 4, MOV reg/MVN 4, ADD/AND 5, illegal 1.
//  - Back-to-back: s held high is level-sensitive; a new instruction starts on the first WAIT cycle.
//  - At most one of loada/loadb/loadc/write is high in any cycle; write is never high in WAIT.
// TESTING
//  - reset=1 mid-GET_B:
//    w=1 and loadb=0 without waiting for a clock edge; state stays WAIT after release with s=0.
//  - MOV R2,#5 (opcode 110, op 10), s pulse:
//    cycle after DECODE: write=1, nsel=100, vsel=01; w=1 on the next edge; R2 reads 5.
//  - ADD (101/00), s pulse:
//    loada, loadb, loadc, write each high for exactly 1 cycle, in that order; w after 5 edges.
//  - CMP (101/01):
//    loads=1 and loadc=0 in EXEC; write never asserted; back in WAIT 4 edges after start.
//  - Opcode changed to 110/10 while executing an ADD:
//    sequence completes as ADD; with s held high, MOV imm starts immediately in WAIT.
//  - Illegal opcode 000:
//    DECODE -> WAIT; no load, loads or write seen; w high 1 edge after start.

Source files
------------

// File: rtl/datapath_controller_if.sv
// Control bundle between the instruction decoder/datapath and datapath_controller.
// master = the controller (drives datapath controls), slave = the datapath side.
interface datapath_controller_if;
  localparam int unsigned OPC_W  = 3;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned NSEL_W = 3;
  localparam int unsigned VSEL_W = 2;

  logic              s;
  logic [OPC_W-1:0]  opcode;
  logic [OP_W-1:0]   op;
  logic [NSEL_W-1:0] nsel;
  logic [VSEL_W-1:0] vsel;
  logic              loada;
  logic              loadb;
  logic              asel;
  logic              bsel;
  logic              loadc;
  logic              loads;
  logic              write;
  logic              w;

  modport master (
    input  s, opcode, op,
    output nsel, vsel, loada, loadb, asel, bsel, loadc, loads, write, w
  );

  modport slave (
    output s, opcode, op,
    input  nsel, vsel, loada, loadb, asel, bsel, loadc, loads, write, w
  );
endinterface

// File: rtl/datapath_controller.sv
// Moore sequencer for the regfile/ALU datapath: one 16-bit instruction at a time,
// w high when idle in WAIT and ready for the next start strobe.
module datapath_controller #(
  parameter logic [2:0] OPC_MOV = 3'b110,
  parameter logic [2:0] OPC_ALU = 3'b101
) (
  input  logic                  clk,
  input  logic                  reset,
  datapath_controller_if.master bus
);
  localparam int unsigned OPC_W = 3;
  localparam int unsigned OP_W  = 2;

  localparam logic [OP_W-1:0] OP_MOV_REG = 2'b00;
  localparam logic [OP_W-1:0] OP_MOV_IMM = 2'b10;
  localparam logic [OP_W-1:0] OP_ADD     = 2'b00;
  localparam logic [OP_W-1:0] OP_CMP     = 2'b01;
  localparam logic [OP_W-1:0] OP_AND     = 2'b10;
  localparam logic [OP_W-1:0] OP_MVN     = 2'b11;

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_EXEC      = 3'd5,
    S_WRITE_REG = 3'd6
  } state_t;

  state_t           state_q;
  state_t           state_nxt;
  logic [OPC_W-1:0] opcode_q;
  logic [OP_W-1:0]  op_q;

  logic is_mov_imm;
  logic is_mov_reg;
  logic is_alu;
  logic is_cmp;
  logic is_mvn;
  logic is_add_and;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_WAIT;
    else       state_q <= state_nxt;
  end

  // Instruction fields are frozen on the edge that leaves WAIT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode_q <= '0;
      op_q     <= '0;
    end else if (state_q == S_WAIT && bus.s) begin
      opcode_q <= bus.opcode;
      op_q     <= bus.op;
    end
  end

  always_comb begin
    is_mov_imm = (opcode_q == OPC_MOV) && (op_q == OP_MOV_IMM);
    is_mov_reg = (opcode_q == OPC_MOV) && (op_q == OP_MOV_REG);
    is_alu     = (opcode_q == OPC_ALU);
    is_cmp     = is_alu && (op_q == OP_CMP);
    is_mvn     = is_alu && (op_q == OP_MVN);
    is_add_and = is_alu && ((op_q == OP_ADD) || (op_q == OP_AND));
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      S_WAIT:      if (bus.s) state_nxt = S_DECODE;
      S_DECODE: begin
        if (is_mov_imm)                 state_nxt = S_WRITE_IMM;
        else if (is_mov_reg || is_mvn)  state_nxt = S_GET_B;
        else if (is_add_and || is_cmp)  state_nxt = S_GET_A;
        else                            state_nxt = S_WAIT;
      end
      S_WRITE_IMM: state_nxt = S_WAIT;
      S_GET_A:     state_nxt = S_GET_B;
      S_GET_B:     state_nxt = S_EXEC;
      S_EXEC:      state_nxt = is_cmp ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_nxt = S_WAIT;
      default:     state_nxt = S_WAIT;
    endcase
  end

  // Moore outputs; CMP only updates flags so C keeps its previous result
  always_comb begin
    bus.nsel  = 3'b000;
    bus.vsel  = 2'b00;
    bus.loada = 1'b0;
    bus.loadb = 1'b0;
    bus.asel  = 1'b0;
    bus.bsel  = 1'b0;
    bus.loadc = 1'b0;
    bus.loads = 1'b0;
    bus.write = 1'b0;
    bus.w     = 1'b0;
    unique case (state_q)
      S_WAIT:      bus.w = 1'b1;
      S_WRITE_IMM: begin
        bus.nsel  = 3'b100;
        bus.vsel  = 2'b01;
        bus.write = 1'b1;
      end
      S_GET_A: begin
        bus.nsel  = 3'b100;
        bus.loada = 1'b1;
      end
      S_GET_B: begin
        bus.nsel  = 3'b001;
        bus.loadb = 1'b1;
      end
      S_EXEC: begin
        bus.asel  = is_mov_reg || is_mvn;
        bus.loadc = !is_cmp;
        bus.loads = is_cmp;
      end
      S_WRITE_REG: begin
        bus.nsel  = 3'b010;
        bus.write = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_datapath_controller.sv
// Directed bench for datapath_controller: walks each instruction class cycle by cycle
// and compares the full control vector against hand-derived per-state values.
module tb_datapath_controller;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  datapath_controller_if bus ();

  datapath_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout: {nsel[2:0], vsel[1:0], loada, loadb, asel, bsel, loadc, loads, write, w}
  localparam logic [12:0] E_WAIT = 13'b000_00_00000001;
  localparam logic [12:0] E_DEC  = 13'b000_00_00000000;
  localparam logic [12:0] E_WIMM = 13'b100_01_00000010;
  localparam logic [12:0] E_GETA = 13'b100_00_10000000;
  localparam logic [12:0] E_GETB = 13'b001_00_01000000;
  localparam logic [12:0] E_EXEC = 13'b000_00_00001000;
  localparam logic [12:0] E_EXMV = 13'b000_00_00101000;
  localparam logic [12:0] E_ECMP = 13'b000_00_00000100;
  localparam logic [12:0] E_WREG = 13'b010_00_00000010;

  task automatic chk(input string tag, input logic [12:0] exp);
    logic [12:0] obs;
    obs = {bus.nsel, bus.vsel, bus.loada, bus.loadb, bus.asel, bus.bsel,
           bus.loadc, bus.loads, bus.write, bus.w};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [2:0] opc, input logic [1:0] o);
    bus.opcode = opc;
    bus.op     = o;
    bus.s      = 1'b1;
    step();
    bus.s = 1'b0;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    bus.s      = 1'b0;
    bus.opcode = 3'b000;
    bus.op     = 2'b00;
    #3;
    chk("reset_state", E_WAIT);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("idle_after_reset", E_WAIT);

    // MOV R2,#5
    start(3'b110, 2'b10);
    chk("movi_decode", E_DEC);
    step(); chk("movi_write_imm", E_WIMM);
    step(); chk("movi_back_wait", E_WAIT);

    // ADD: loada, loadb, loadc, write in order, w after 5 edges
    start(3'b101, 2'b00);
    chk("add_decode", E_DEC);
    step(); chk("add_get_a", E_GETA);
    step(); chk("add_get_b", E_GETB);
    step(); chk("add_exec", E_EXEC);
    step(); chk("add_write_reg", E_WREG);
    step(); chk("add_back_wait", E_WAIT);

    // CMP: flags only, no C load, no write, 4 edges
    start(3'b101, 2'b01);
    chk("cmp_decode", E_DEC);
    step(); chk("cmp_get_a", E_GETA);
    step(); chk("cmp_get_b", E_GETB);
    step(); chk("cmp_exec", E_ECMP);
    step(); chk("cmp_back_wait", E_WAIT);

    // MOV Rd,Rm: skips GET_A, A forced to zero
    start(3'b110, 2'b00);
    chk("movr_decode", E_DEC);
    step(); chk("movr_get_b", E_GETB);
    step(); chk("movr_exec", E_EXMV);
    step(); chk("movr_write_reg", E_WREG);
    step(); chk("movr_back_wait", E_WAIT);

    // MVN
    start(3'b101, 2'b11);
    chk("mvn_decode", E_DEC);
    step(); chk("mvn_get_b", E_GETB);
    step(); chk("mvn_exec", E_EXMV);
    step(); chk("mvn_write_reg", E_WREG);
    step(); chk("mvn_back_wait", E_WAIT);

    // AND with opcode switched to MOV imm mid-flight and s held high
    bus.opcode = 3'b101;
    bus.op     = 2'b10;
    bus.s      = 1'b1;
    step();
    bus.opcode = 3'b110;
    bus.op     = 2'b10;
    chk("and_decode", E_DEC);
    step(); chk("and_get_a", E_GETA);
    step(); chk("and_get_b", E_GETB);
    step(); chk("and_exec", E_EXEC);
    step(); chk("and_write_reg", E_WREG);
    step(); chk("and_back_wait", E_WAIT);
    step(); chk("b2b_movi_decode", E_DEC);
    bus.s = 1'b0;
    step(); chk("b2b_movi_write_imm", E_WIMM);
    step(); chk("b2b_movi_back_wait", E_WAIT);

    // Illegal opcode 000
    start(3'b000, 2'b00);
    chk("ill_opc_decode", E_DEC);
    step(); chk("ill_opc_back_wait", E_WAIT);

    // Illegal MOV sub-op
    start(3'b110, 2'b01);
    chk("ill_op_decode", E_DEC);
    step(); chk("ill_op_back_wait", E_WAIT);

    // Async reset in GET_B takes effect before any clock edge
    start(3'b101, 2'b00);
    chk("rst_mid_decode", E_DEC);
    step(); chk("rst_mid_get_a", E_GETA);
    step(); chk("rst_mid_get_b", E_GETB);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_async", E_WAIT);
    step(); chk("rst_mid_held", E_WAIT);
    @(negedge clk);
    reset = 1'b0;
    step(); chk("rst_mid_release_1", E_WAIT);
    step(); chk("rst_mid_release_2", E_WAIT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
